// File: rtl/universal_shift_reg.sv
// Universal shift register: hold, shift right/left, parallel load, with a fill counter.
// Define SHIFT_ROTATE_EN to let rot=1 recirculate the end stage instead of taking a.
module universal_shift_reg #(
  parameter int WIDTH = 1,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     en,
  input  logic [1:0]               mode,
  input  logic                     rot,
  input  logic [WIDTH-1:0]         a,
  input  logic [DEPTH*WIDTH-1:0]   pin,
  output logic [WIDTH-1:0]         q,
  output logic [WIDTH-1:0]         ql,
  output logic [DEPTH*WIDTH-1:0]   pout,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                     full
);

  localparam int CW = $clog2(DEPTH+1);

  typedef enum logic [1:0] {
    M_HOLD = 2'b00,
    M_SHR  = 2'b01,
    M_SHL  = 2'b10,
    M_LOAD = 2'b11
  } mode_e;

  logic [DEPTH-1:0][WIDTH-1:0] stage_q, stage_d, pin_arr;
  logic [CW-1:0]               count_q, count_d;
  logic                        full_q, full_d;
  logic                        rot_act;
  logic [WIDTH-1:0]            shr_in, shl_in;

`ifdef SHIFT_ROTATE_EN
  assign rot_act = rot;
`else
  logic unused_rot;
  assign unused_rot = rot;
  assign rot_act    = 1'b0;
`endif

  assign pin_arr = pin;
  assign shr_in  = rot_act ? stage_q[DEPTH-1] : a;
  assign shl_in  = rot_act ? stage_q[0]       : a;

  always_comb begin
    stage_d = stage_q;
    count_d = count_q;
    if (en) begin
      unique case (mode_e'(mode))
        M_SHR: begin
          stage_d[0] = shr_in;
          for (int i = 1; i < DEPTH; i++) stage_d[i] = stage_q[i-1];
        end
        M_SHL: begin
          stage_d[DEPTH-1] = shl_in;
          for (int i = 0; i < DEPTH-1; i++) stage_d[i] = stage_q[i+1];
        end
        M_LOAD:  stage_d = pin_arr;
        default: ;
      endcase
      if (mode == M_LOAD)
        count_d = CW'(DEPTH);
      else if ((mode == M_SHR || mode == M_SHL) && !rot_act && count_q != CW'(DEPTH))
        count_d = count_q + CW'(1);
    end
    // full is registered so every output comes straight from a flop
    full_d = (count_d == CW'(DEPTH));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stage_q <= '0;
      count_q <= '0;
      full_q  <= 1'b0;
    end else begin
      stage_q <= stage_d;
      count_q <= count_d;
      full_q  <= full_d;
    end
  end

  assign pout  = stage_q;
  assign q     = stage_q[DEPTH-1];
  assign ql    = stage_q[0];
  assign count = count_q;
  assign full  = full_q;

endmodule

// File: tb/tb_universal_shift_reg.sv
// Directed bench for universal_shift_reg: 1x4 instance plus an 8-bit x 3-stage instance.
module tb_universal_shift_reg;

  logic       clk = 1'b0;
  logic       rst;
  int         errs = 0;
  int         checks = 0;

  logic       en, rot;
  logic [1:0] mode;
  logic       a;
  logic [3:0] pin;
  logic       q, ql, full;
  logic [3:0] pout;
  logic [2:0] count;

  logic        en8;
  logic [1:0]  mode8;
  logic [7:0]  a8, q8, ql8;
  logic [23:0] pin8, pout8;
  logic [1:0]  count8;
  logic        full8;

  always #5 clk = ~clk;

  universal_shift_reg #(.WIDTH(1), .DEPTH(4)) dut (
    .clk(clk), .rst(rst), .en(en), .mode(mode), .rot(rot), .a(a), .pin(pin),
    .q(q), .ql(ql), .pout(pout), .count(count), .full(full)
  );

  universal_shift_reg #(.WIDTH(8), .DEPTH(3)) dut8 (
    .clk(clk), .rst(rst), .en(en8), .mode(mode8), .rot(1'b0), .a(a8), .pin(pin8),
    .q(q8), .ql(ql8), .pout(pout8), .count(count8), .full(full8)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    #1;
    checks++;
    if (pout !== 4'b0000 || count !== 3'd0 || full !== 1'b0 || q !== 1'b0 || ql !== 1'b0) begin
      errs++;
      $display("FAIL reset: pout=%b count=%0d full=%b q=%b ql=%b, want 0000/0/0/0/0",
               pout, count, full, q, ql);
    end
    do_reset();
  endtask

  task automatic test_fill();
    logic [3:0] av;
    av = 4'b1101;  // a = 1,0,1,1 applied LSB first
    do_reset();
    en = 1'b1; mode = 2'b01; rot = 1'b0;
    for (int i = 0; i < 4; i++) begin
      a = av[i];
      step();
      checks++;
      if (count !== 3'(i + 1) || full !== (i == 3)) begin
        errs++;
        $display("FAIL fill_count[%0d]: count=%0d full=%b, want %0d/%b", i, count, full, i + 1, i == 3);
      end
    end
    checks++;
    if (pout !== 4'b1011 || q !== 1'b1 || ql !== 1'b1) begin
      errs++;
      $display("FAIL fill_data: pout=%b q=%b ql=%b, want 1011/1/1", pout, q, ql);
    end
    a = 1'b0;
    step();
    checks++;
    if (count !== 3'd4 || full !== 1'b1 || pout !== 4'b0110) begin
      errs++;
      $display("FAIL fill_sat: count=%0d full=%b pout=%b, want 4/1/0110", count, full, pout);
    end
  endtask

  task automatic test_load_shl();
    do_reset();
    en = 1'b1; mode = 2'b11; pin = 4'b1001;
    step();
    checks++;
    if (pout !== 4'b1001 || count !== 3'd4 || full !== 1'b1) begin
      errs++;
      $display("FAIL load: pout=%b count=%0d full=%b, want 1001/4/1", pout, count, full);
    end
    mode = 2'b10; a = 1'b0;
    step();
    checks++;
    if (pout !== 4'b0100 || ql !== 1'b0 || count !== 3'd4) begin
      errs++;
      $display("FAIL shl: pout=%b ql=%b count=%0d, want 0100/0/4", pout, ql, count);
    end
    a = 1'b1;
    step();
    checks++;
    if (pout !== 4'b1010 || q !== 1'b1) begin
      errs++;
      $display("FAIL shl_a1: pout=%b q=%b, want 1010/1", pout, q);
    end
  endtask

  task automatic test_hold();
    do_reset();
    en = 1'b1; mode = 2'b11; pin = 4'b0110;
    step();
    en = 1'b0; mode = 2'b01; a = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      checks++;
      if (pout !== 4'b0110 || count !== 3'd4) begin
        errs++;
        $display("FAIL hold_en0[%0d]: pout=%b count=%0d, want 0110/4", i, pout, count);
      end
    end
    en = 1'b1; mode = 2'b00;
    for (int i = 0; i < 2; i++) begin
      step();
      checks++;
      if (pout !== 4'b0110) begin
        errs++;
        $display("FAIL hold_m00[%0d]: pout=%b, want 0110", i, pout);
      end
    end
  endtask

  task automatic test_async_reset();
    do_reset();
    en = 1'b1; mode = 2'b01; a = 1'b1;
    step();
    step();
    checks++;
    if (pout !== 4'b0011 || count !== 3'd2) begin
      errs++;
      $display("FAIL pre_rst: pout=%b count=%0d, want 0011/2", pout, count);
    end
    #2 rst = 1'b1;
    #1;
    checks++;
    if (pout !== 4'b0000 || count !== 3'd0 || full !== 1'b0) begin
      errs++;
      $display("FAIL async_rst: pout=%b count=%0d full=%b, want 0000/0/0", pout, count, full);
    end
    mode = 2'b11; pin = 4'hF;
    step();
    step();
    checks++;
    if (pout !== 4'b0000 || count !== 3'd0) begin
      errs++;
      $display("FAIL rst_held: pout=%b count=%0d, want 0000/0", pout, count);
    end
    #2 rst = 1'b0;
    mode = 2'b01; a = 1'b1;
    step();
    checks++;
    if (pout !== 4'b0001 || count !== 3'd1) begin
      errs++;
      $display("FAIL post_rst: pout=%b count=%0d, want 0001/1", pout, count);
    end
  endtask

  task automatic test_rotate();
    logic [3:0] exp_p [4];
`ifdef SHIFT_ROTATE_EN
    exp_p = '{4'b0001, 4'b0010, 4'b0100, 4'b1000};
`else
    exp_p = '{4'b0000, 4'b0000, 4'b0000, 4'b0000};
`endif
    do_reset();
    en = 1'b1; mode = 2'b11; pin = 4'b1000;
    step();
    mode = 2'b01; rot = 1'b1; a = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step();
      checks++;
      if (pout !== exp_p[i] || count !== 3'd4) begin
        errs++;
        $display("FAIL rotate[%0d]: pout=%b count=%0d, want %b/4", i, pout, count, exp_p[i]);
      end
    end
    rot = 1'b0;
  endtask

  task automatic test_wide();
    logic [7:0] av [3];
    av = '{8'hA5, 8'h3C, 8'hFF};
    en = 1'b0;
    do_reset();
    en8 = 1'b1; mode8 = 2'b01;
    for (int i = 0; i < 3; i++) begin
      a8 = av[i];
      step();
      checks++;
      if (count8 !== 2'(i + 1)) begin
        errs++;
        $display("FAIL wide_count[%0d]: count=%0d, want %0d", i, count8, i + 1);
      end
    end
    checks++;
    if (pout8 !== 24'hA53CFF || q8 !== 8'hA5 || ql8 !== 8'hFF || full8 !== 1'b1) begin
      errs++;
      $display("FAIL wide: pout=%h q=%h ql=%h full=%b, want a53cff/a5/ff/1", pout8, q8, ql8, full8);
    end
    en8 = 1'b0;
  endtask

  initial begin
    rst = 1'b1; en = 1'b0; mode = 2'b00; rot = 1'b0; a = 1'b0; pin = '0;
    en8 = 1'b0; mode8 = 2'b00; a8 = '0; pin8 = '0;
    test_reset();
    test_fill();
    test_load_shl();
    test_hold();
    test_async_reset();
    test_rotate();
    test_wide();
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
